dma_fetch: RTL and testbench

DMA_FETCH -- requirements
Module: dma_fetch

---
 rtl/dma_fetch.sv | 130 +++++++++++++
 tb/tb_dma_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fetch.sv
// Block fetch engine: reads 8x8 blocks (16 words each) from a Wishbone
// classic slave into a block buffer, handshaking each full block downstream.
module dma_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        resetaddr_o,
    output logic        incaddr_o,
    input  logic [31:0] address_i,
    input  logic        endblock_i,
    input  logic        endframe_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        buf_we_o,
    output logic [3:0]  buf_addr_o,
    output logic [31:0] buf_data_o,
    output logic        block_ready_o,
    input  logic        block_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_WAIT_BUF,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [7:0]  tcnt_q;
    logic        last_q;

    logic        in_read;
    logic        ack_ok;

    // Abort must silence the bus and buffer in the very cycle it is seen.
    assign in_read = (state_q == S_READ) && !abort_i;
    assign ack_ok  = in_read && wb_ack_i && !wb_err_i;

    assign wb_cyc_o      = in_read;
    assign wb_stb_o      = in_read;
    assign wb_we_o       = 1'b0;
    assign wb_adr_o      = in_read ? address_i : 32'd0;

    assign buf_we_o      = ack_ok;
    assign buf_addr_o    = ack_ok ? wcnt_q : 4'd0;
    assign buf_data_o    = ack_ok ? wb_dat_i : 32'd0;
    assign incaddr_o     = ack_ok;
    assign resetaddr_o   = (state_q == S_INIT) && !abort_i;

    assign block_ready_o = (state_q == S_WAIT_BUF) && !abort_i;
    assign busy_o        = (state_q == S_INIT) || (state_q == S_READ) || (state_q == S_WAIT_BUF);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERROR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            tcnt_q  <= 8'd0;
            last_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start_i) begin
                        state_q <= S_INIT;
                        wcnt_q  <= 4'd0;
                        tcnt_q  <= 8'd0;
                        last_q  <= 1'b0;
                    end
                end
                S_INIT: begin
                    state_q <= S_READ;
                end
                S_READ: begin
                    // ack+err together counts as an error and is never written.
                    if (wb_err_i) begin
                        state_q <= S_ERROR;
                    end else if (wb_ack_i) begin
                        wcnt_q <= wcnt_q + 4'd1;
                        tcnt_q <= 8'd0;
                        if (endblock_i) begin
                            if (wcnt_q != 4'd15) begin
                                state_q <= S_ERROR;
                            end else begin
                                last_q  <= endframe_i;
                                state_q <= S_WAIT_BUF;
                            end
                        end
                    end else if (tcnt_q >= TO_LAST) begin
                        state_q <= S_ERROR;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                S_WAIT_BUF: begin
                    if (block_ack_i) begin
                        wcnt_q  <= 4'd0;
                        tcnt_q  <= 8'd0;
                        state_q <= last_q ? S_DONE : S_READ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fetch.sv
// Testbench for dma_fetch: cycle-vector table plus address-generator driven frame sequences.
module tb_dma_fetch;

    localparam int TO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, start_i, abort_i;
    logic        resetaddr_o, incaddr_o;
    logic [31:0] address_i;
    logic        endblock_i, endframe_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        buf_we_o;
    logic [3:0]  buf_addr_o;
    logic [31:0] buf_data_o;
    logic        block_ready_o, block_ack_i;
    logic        busy_o, done_o, err_o;

    dma_fetch #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .resetaddr_o(resetaddr_o), .incaddr_o(incaddr_o),
        .address_i(address_i), .endblock_i(endblock_i), .endframe_i(endframe_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o), .buf_data_o(buf_data_o),
        .block_ready_o(block_ready_o), .block_ack_i(block_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Address generator model: 8 rows x 2 words per block, blocks tiled across/down.
    bit          use_model = 1'b0;
    logic [31:0] tbl_addr;
    logic        tbl_eb, tbl_ef;
    logic [31:0] m_src, m_pitch, m_ex, m_ey;
    logic [31:0] m_row = 0, m_col = 0, m_bx = 0, m_by = 0;
    logic        m_eb, m_ef;

    always_comb begin
        m_eb = (m_row == 32'd7) && (m_col == 32'd1);
        m_ef = m_eb && (m_bx == m_ex) && (m_by == m_ey);
        address_i  = use_model ? (m_src + m_by * 32'd8 * m_pitch + m_bx * 32'd8
                                  + m_row * m_pitch + m_col * 32'd4) : tbl_addr;
        endblock_i = use_model ? m_eb : tbl_eb;
        endframe_i = use_model ? m_ef : tbl_ef;
    end

    always @(posedge clk) begin
        if (resetaddr_o) begin
            m_row <= 0; m_col <= 0; m_bx <= 0; m_by <= 0;
        end else if (incaddr_o) begin
            if (m_col == 0) begin
                m_col <= 1;
            end else begin
                m_col <= 0;
                if (m_row != 7) m_row <= m_row + 1;
                else begin
                    m_row <= 0;
                    if (m_bx != m_ex) m_bx <= m_bx + 1;
                    else begin
                        m_bx <= 0;
                        m_by <= m_by + 1;
                    end
                end
            end
        end
    end

    function automatic logic [11:0] obs();
        return {wb_cyc_o, buf_we_o, buf_addr_o, incaddr_o, resetaddr_o,
                block_ready_o, busy_o, done_o, err_o};
    endfunction

    typedef struct packed {
        logic s, a, ack, err, eb, ef, bk;
        logic [11:0] exp;   // cyc we ba[3:0] inc rsta rdy busy done err
    } vec_t;
    vec_t tbl[16];

    // Statistics gathered by run()
    int          n_wr, n_done, n_cyc, n_rsta, n_back;
    logic [31:0] wr_adr[64];

    task automatic clear_stats();
        n_wr = 0; n_done = 0; n_cyc = 0; n_rsta = 0; n_back = 0;
    endtask

    task automatic clear_inputs();
        start_i = 0; abort_i = 0; wb_ack_i = 0; wb_err_i = 0; block_ack_i = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        clear_inputs();
        start_i = 1;
    endtask

    // Runs a slave with ws wait states per word until done_o, err_o or
    // (optionally) block_ready_o is seen; expiry of maxc cycles is a failure.
    task automatic run(input int maxc, input int ws, input int err_word, input bit no_ack,
                       input bit auto_back, input bit stop_rdy);
        int  wcnt = 0;
        int  words = 0;
        int  rdy = 0;
        bit  hit = 0;
        for (int c = 0; c < maxc && !hit; c++) begin
            @(negedge clk);
            clear_inputs();
            wb_dat_i = $urandom;
            if (wb_cyc_o && !no_ack) begin
                if (wcnt < ws) wcnt++;
                else begin
                    wcnt = 0;
                    if (words == err_word) wb_err_i = 1;
                    else wb_ack_i = 1;
                    words++;
                end
            end
            if (block_ready_o && auto_back) begin
                rdy++;
                if (rdy >= 2) begin
                    block_ack_i = 1;
                    rdy = 0;
                    n_back++;
                end
            end
            #1;
            chk("inc_rsta_exclusive", {31'd0, incaddr_o & resetaddr_o}, 32'd0);
            if (wb_cyc_o) n_cyc++;
            if (resetaddr_o) n_rsta++;
            if (buf_we_o) begin
                chk("buf_data", buf_data_o, wb_dat_i);
                chk("buf_addr", {28'd0, buf_addr_o}, 32'(n_wr % 16));
                if (n_wr < 64) wr_adr[n_wr] = wb_adr_o;
                n_wr++;
            end
            if (done_o) n_done++;
            if (done_o || err_o || (stop_rdy && block_ready_o)) hit = 1;
        end
        if (!hit) begin
            errors++;
            checks++;
            $display("FAIL run_bound no terminating event within %0d cycles", maxc);
        end
    endtask

    initial begin
        int bad;
        clear_inputs();
        wb_dat_i = 0;
        tbl_addr = 0; tbl_eb = 0; tbl_ef = 0;
        m_src = 0; m_pitch = 0; m_ex = 0; m_ey = 0;
        rst_i = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {20'd0, obs()}, 32'd0);
        chk("reset_adr", wb_adr_o, 32'd0);
        chk("reset_we_stb", {30'd0, wb_we_o, wb_stb_o}, 32'd0);
        @(negedge clk);
        rst_i = 0;

        //               s a k e b f bk  cyc we ba   inc rst rdy busy done err
        tbl[0]  = '{0,0,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_0};
        tbl[1]  = '{1,0,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_0};
        tbl[2]  = '{0,0,0,0,0,0,0, 12'b0_0_0000_0_1_0_1_0_0};
        tbl[3]  = '{0,0,0,0,0,0,0, 12'b1_0_0000_0_0_0_1_0_0};
        tbl[4]  = '{1,0,1,0,0,0,0, 12'b1_1_0000_1_0_0_1_0_0};
        tbl[5]  = '{1,0,1,0,0,0,0, 12'b1_1_0001_1_0_0_1_0_0};
        tbl[6]  = '{0,0,1,0,1,0,0, 12'b1_1_0010_1_0_0_1_0_0};
        tbl[7]  = '{0,0,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_1};
        tbl[8]  = '{1,1,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_1};
        tbl[9]  = '{1,0,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_0};
        tbl[10] = '{0,0,0,0,0,0,0, 12'b0_0_0000_0_1_0_1_0_0};
        tbl[11] = '{0,0,1,1,0,0,0, 12'b1_0_0000_0_0_0_1_0_0};
        tbl[12] = '{1,0,0,0,0,0,0, 12'b0_0_0000_0_0_0_0_0_1};
        tbl[13] = '{0,0,0,0,0,0,0, 12'b0_0_0000_0_1_0_1_0_0};
        tbl[14] = '{0,1,1,0,0,0,0, 12'b0_0_0000_0_0_0_1_0_0};
        tbl[15] = '{0,0,0,0,0,0,1, 12'b0_0_0000_0_0_0_0_0_0};

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start_i = tbl[i].s; abort_i = tbl[i].a;
            wb_ack_i = tbl[i].ack; wb_err_i = tbl[i].err;
            tbl_eb = tbl[i].eb; tbl_ef = tbl[i].ef; block_ack_i = tbl[i].bk;
            tbl_addr = 32'hA000_0000 + 32'(i);
            wb_dat_i = 32'hC0DE_0000 + 32'(i);
            #1;
            $display("vec %0d outputs=%b", i, obs());
            chk($sformatf("vec%0d_outputs", i), {20'd0, obs()}, {20'd0, tbl[i].exp});
            chk($sformatf("vec%0d_adr", i), wb_adr_o, tbl[i].exp[11] ? tbl_addr : 32'd0);
        end

        // Single block, pitch 8: contiguous 0x100..0x13C, one done pulse.
        use_model = 1; m_src = 32'h100; m_pitch = 8; m_ex = 0; m_ey = 0;
        clear_stats();
        pulse_start();
        run(200, 0, -1, 0, 1, 0);
        bad = 0;
        for (int k = 0; k < 16; k++) if (wr_adr[k] !== 32'h100 + 32'(4 * k)) bad++;
        $display("single block: writes=%0d done=%0d", n_wr, n_done);
        chk("blk1_writes", 32'(n_wr), 32'd16);
        chk("blk1_addr_mismatches", 32'(bad), 32'd0);
        chk("blk1_done_count", 32'(n_done), 32'd1);
        chk("blk1_rsta_count", 32'(n_rsta), 32'd1);
        @(negedge clk); clear_inputs(); #1;
        chk("blk1_done_one_cycle", {31'd0, done_o}, 32'd0);

        // Two blocks wide, pitch 16.
        m_pitch = 16; m_ex = 1; m_ey = 0;
        clear_stats();
        pulse_start();
        run(300, 0, -1, 0, 1, 0);
        $display("two blocks: writes=%0d block_acks=%0d done=%0d", n_wr, n_back, n_done);
        chk("blk2_writes", 32'(n_wr), 32'd32);
        chk("blk2_word2_adr", wr_adr[2], 32'h110);
        chk("blk2_second_start", wr_adr[16], 32'h108);
        chk("blk2_last_adr", wr_adr[31], 32'h108 + 32'd7 * 32'd16 + 32'd4);
        chk("blk2_block_acks", 32'(n_back), 32'd2);
        chk("blk2_done_count", 32'(n_done), 32'd1);

        // Three wait states per word (below the timeout of 4).
        m_pitch = 8; m_ex = 0;
        clear_stats();
        pulse_start();
        run(400, 3, -1, 0, 1, 0);
        $display("wait states: writes=%0d bus_cycles=%0d", n_wr, n_cyc);
        chk("ws3_writes", 32'(n_wr), 32'd16);
        chk("ws3_bus_cycles", 32'(n_cyc), 32'd64);

        // Bus error on word 5, then restart.
        clear_stats();
        pulse_start();
        run(200, 0, 5, 0, 1, 0);
        $display("bus error: writes=%0d err=%b cyc=%b", n_wr, err_o, wb_cyc_o);
        chk("berr_writes", 32'(n_wr), 32'd5);
        chk("berr_err_o", {31'd0, err_o}, 32'd1);
        chk("berr_cyc_released", {31'd0, wb_cyc_o}, 32'd0);
        clear_stats();
        pulse_start();
        run(200, 0, -1, 0, 1, 0);
        chk("berr_restart_adr", wr_adr[0], 32'h100);
        chk("berr_restart_writes", 32'(n_wr), 32'd16);

        // Silent slave: error after TO READ cycles.
        clear_stats();
        pulse_start();
        run(50, 0, -1, 1, 1, 0);
        $display("timeout: read cycles=%0d err=%b", n_cyc, err_o);
        chk("tmo_read_cycles", 32'(n_cyc), 32'(TO));
        chk("tmo_err_o", {31'd0, err_o}, 32'd1);
        chk("tmo_writes", 32'(n_wr), 32'd0);

        // Abort while waiting on the downstream buffer.
        clear_stats();
        pulse_start();
        run(200, 0, -1, 0, 0, 1);
        chk("abort_ready_seen", {31'd0, block_ready_o}, 32'd1);
        @(negedge clk); clear_inputs(); abort_i = 1; #1;
        chk("abort_ready_dropped", {31'd0, block_ready_o}, 32'd0);
        @(negedge clk); clear_inputs(); #1;
        chk("abort_idle", {20'd0, obs()}, 32'd0);
        pulse_start();
        @(negedge clk); clear_inputs(); #1;
        $display("after abort restart: resetaddr=%b busy=%b", resetaddr_o, busy_o);
        chk("abort_restart_rsta", {31'd0, resetaddr_o}, 32'd1);

        // Reset in the middle of a transfer.
        @(negedge clk); #1;
        chk("mid_cyc_active", {31'd0, wb_cyc_o}, 32'd1);
        @(negedge clk); rst_i = 1; wb_ack_i = 0;
        @(negedge clk); rst_i = 0; wb_ack_i = 1; #1;
        $display("mid reset: cyc=%b we=%b busy=%b", wb_cyc_o, buf_we_o, busy_o);
        chk("mid_reset_outputs", {20'd0, obs()}, 32'd0);
        @(negedge clk); clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
